// File: rtl/roi_pkg.sv
// Shared register map, bit positions, coordinate field layout and FSM states for roi_ctrl.
package roi_pkg;

    localparam int ADDR_CTRL      = 'h000;
    localparam int ADDR_XY0       = 'h004;
    localparam int ADDR_XY1       = 'h008;
    localparam int ADDR_STATUS    = 'h00C;
    localparam int ADDR_FRAME_CNT = 'h010;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_COMMIT_BIT = 1;

    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_ERR_BIT  = 1;
    localparam int STAT_RUN_BIT  = 2;

    localparam int X_LSB = 16;
    localparam int X_MSB = 26;
    localparam int Y_LSB = 0;
    localparam int Y_MSB = 9;
    localparam int XW    = X_MSB - X_LSB + 1;
    localparam int YW    = Y_MSB - Y_LSB + 1;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } roi_state_e;

endpackage

// File: rtl/roi_ctrl_regs.sv
// APB slave with zero wait states: address decode, enable and shadow corner registers,
// commit / cfg_err-clear strobes and the read-back mux.
module roi_ctrl_regs
    import roi_pkg::*;
#(
    parameter int WIDTH      = 800,
    parameter int HEIGHT     = 600,
    parameter int APB_DATA_W = 32,
    parameter int APB_ADDR_W = 12
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [APB_DATA_W-1:0]  apb_pwdata_i,
    input  logic [APB_ADDR_W-1:0]  apb_paddr_i,
    input  logic                   apb_pwrite_i,
    input  logic                   apb_psel_i,
    input  logic                   apb_penable_i,
    output logic                   apb_pready_o,
    output logic [APB_DATA_W-1:0]  apb_prdata_o,
    output logic                   o_enable,
    output logic [XW-1:0]          o_x0,
    output logic [YW-1:0]          o_y0,
    output logic [XW-1:0]          o_x1,
    output logic [YW-1:0]          o_y1,
    output logic                   o_commit,
    output logic                   o_err_clr,
    input  logic                   i_pending,
    input  logic                   i_cfg_err,
    input  logic                   i_running,
    input  logic [FRAME_CNT_W-1:0] i_frame_cnt
);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    logic                  r_enable;
    logic [XW-1:0]         r_x0, r_x1;
    logic [YW-1:0]         r_y0, r_y1;
    logic                  w_access, w_wr, w_rd;
    logic                  w_sel_ctrl, w_sel_xy0, w_sel_xy1, w_sel_stat, w_sel_cnt;
    logic [APB_DATA_W-1:0] w_rdata;
    logic                  w_unused;

    assign w_access = apb_psel_i & apb_penable_i;
    assign w_wr     = w_access & apb_pwrite_i;
    assign w_rd     = w_access & ~apb_pwrite_i;

    assign w_sel_ctrl = (apb_paddr_i == APB_ADDR_W'(ADDR_CTRL));
    assign w_sel_xy0  = (apb_paddr_i == APB_ADDR_W'(ADDR_XY0));
    assign w_sel_xy1  = (apb_paddr_i == APB_ADDR_W'(ADDR_XY1));
    assign w_sel_stat = (apb_paddr_i == APB_ADDR_W'(ADDR_STATUS));
    assign w_sel_cnt  = (apb_paddr_i == APB_ADDR_W'(ADDR_FRAME_CNT));

    assign w_unused = ^{apb_pwdata_i[APB_DATA_W-1:X_MSB+1], apb_pwdata_i[X_LSB-1:Y_MSB+1]};

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            r_enable <= 1'b0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= X_MAX;
            r_y1     <= Y_MAX;
        end else if (w_wr) begin
            if (w_sel_ctrl) begin
                r_enable <= apb_pwdata_i[CTRL_EN_BIT];
            end
            if (w_sel_xy0) begin
                r_x0 <= apb_pwdata_i[X_MSB:X_LSB];
                r_y0 <= apb_pwdata_i[Y_MSB:Y_LSB];
            end
            if (w_sel_xy1) begin
                r_x1 <= apb_pwdata_i[X_MSB:X_LSB];
                r_y1 <= apb_pwdata_i[Y_MSB:Y_LSB];
            end
        end
    end

    // Single-cycle strobes; pending and cfg_err live with the frame logic in the top.
    assign o_commit  = w_wr & w_sel_ctrl & apb_pwdata_i[CTRL_COMMIT_BIT];
    assign o_err_clr = w_wr & w_sel_stat & apb_pwdata_i[STAT_ERR_BIT];

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            if (w_sel_ctrl) begin
                w_rdata[CTRL_EN_BIT]     = r_enable;
                w_rdata[CTRL_COMMIT_BIT] = i_pending;
            end else if (w_sel_xy0) begin
                w_rdata[X_MSB:X_LSB] = r_x0;
                w_rdata[Y_MSB:Y_LSB] = r_y0;
            end else if (w_sel_xy1) begin
                w_rdata[X_MSB:X_LSB] = r_x1;
                w_rdata[Y_MSB:Y_LSB] = r_y1;
            end else if (w_sel_stat) begin
                w_rdata[STAT_PEND_BIT] = i_pending;
                w_rdata[STAT_ERR_BIT]  = i_cfg_err;
                w_rdata[STAT_RUN_BIT]  = i_running;
            end else if (w_sel_cnt) begin
                w_rdata[FRAME_CNT_W-1:0] = i_frame_cnt;
            end
        end
    end

    assign apb_pready_o = w_access;
    assign apb_prdata_o = w_rdata;
    assign o_enable     = r_enable;
    assign o_x0         = r_x0;
    assign o_y0         = r_y0;
    assign o_x1         = r_x1;
    assign o_y1         = r_y1;

endmodule

// File: rtl/roi_ctrl.sv
// ROI controller top: enable FSM, frame-synchronous commit of shadow corners with range check.
// Optional frame counter is built only when ROI_CTRL_FRAME_CNT_EN is defined.
module roi_ctrl
    import roi_pkg::*;
#(
    parameter int WIDTH      = 800,
    parameter int HEIGHT     = 600,
    parameter int APB_DATA_W = 32,
    parameter int APB_ADDR_W = 12
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  tvalid_i,
    input  logic                  tlast_i,
    input  logic [APB_DATA_W-1:0] apb_pwdata_i,
    input  logic [APB_ADDR_W-1:0] apb_paddr_i,
    input  logic                  apb_pwrite_i,
    input  logic                  apb_psel_i,
    input  logic                  apb_penable_i,
    output logic                  apb_pready_o,
    output logic [APB_DATA_W-1:0] apb_prdata_o,
    output logic [APB_DATA_W-1:0] xy_0_o,
    output logic [APB_DATA_W-1:0] xy_1_o,
    output logic                  roi_en_o,
    output logic                  irq_o
);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    roi_state_e             r_state, w_state_next;
    logic                   r_pending, r_cfg_err;
    logic [XW-1:0]          r_act_x [2];
    logic [YW-1:0]          r_act_y [2];
    logic [XW-1:0]          w_sh_x  [2];
    logic [YW-1:0]          w_sh_y  [2];
    logic [APB_DATA_W-1:0]  w_xy    [2];
    logic                   w_eof, w_enable, w_commit, w_err_clr, w_ok, w_apply, w_running;
    logic [FRAME_CNT_W-1:0] w_frame_cnt;

    assign w_eof = tvalid_i & tlast_i;

    roi_ctrl_regs #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .APB_DATA_W (APB_DATA_W),
        .APB_ADDR_W (APB_ADDR_W)
    ) u_regs (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .apb_pwdata_i  (apb_pwdata_i),
        .apb_paddr_i   (apb_paddr_i),
        .apb_pwrite_i  (apb_pwrite_i),
        .apb_psel_i    (apb_psel_i),
        .apb_penable_i (apb_penable_i),
        .apb_pready_o  (apb_pready_o),
        .apb_prdata_o  (apb_prdata_o),
        .o_enable      (w_enable),
        .o_x0          (w_sh_x[0]),
        .o_y0          (w_sh_y[0]),
        .o_x1          (w_sh_x[1]),
        .o_y1          (w_sh_y[1]),
        .o_commit      (w_commit),
        .o_err_clr     (w_err_clr),
        .i_pending     (r_pending),
        .i_cfg_err     (r_cfg_err),
        .i_running     (w_running),
        .i_frame_cnt   (w_frame_cnt)
    );

    assign w_ok = (w_sh_x[0] <= w_sh_x[1]) && (w_sh_x[1] <= X_MAX) &&
                  (w_sh_y[0] <= w_sh_y[1]) && (w_sh_y[1] <= Y_MAX);
    assign w_apply = w_eof & r_pending;

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            r_state    <= ST_OFF;
            r_pending  <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_act_x[0] <= '0;
            r_act_y[0] <= '0;
            r_act_x[1] <= X_MAX;
            r_act_y[1] <= Y_MAX;
        end else begin
            r_state <= w_state_next;
            if (w_apply && w_ok) begin
                for (int i = 0; i < 2; i++) begin
                    r_act_x[i] <= w_sh_x[i];
                    r_act_y[i] <= w_sh_y[i];
                end
            end
            // A commit landing on the EOF cycle survives to the following EOF.
            r_pending <= w_commit | (r_pending & ~w_eof);
            r_cfg_err <= (w_apply & ~w_ok) | (r_cfg_err & ~w_err_clr);
        end
    end

    always_comb begin
        w_state_next = r_state;
        roi_en_o     = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_enable) w_state_next = ST_ARM;
            end
            ST_ARM: begin
                if (!w_enable)  w_state_next = ST_OFF;
                else if (w_eof) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                roi_en_o = 1'b1;
                if (!w_enable) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                roi_en_o = 1'b1;
                if (w_eof)         w_state_next = ST_OFF;
                else if (w_enable) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_OFF;
        endcase
    end

    assign w_running = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign irq_o     = r_cfg_err;

`ifdef ROI_CTRL_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            r_frame_cnt <= '0;
        end else if (w_eof && (r_state == ST_RUN)) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign w_frame_cnt = r_frame_cnt;
`else
    assign w_frame_cnt = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_xy
            assign w_xy[gi] = {{(APB_DATA_W-X_MSB-1){1'b0}}, r_act_x[gi],
                               {(X_LSB-Y_MSB-1){1'b0}}, r_act_y[gi]};
        end
    endgenerate

    assign xy_0_o = w_xy[0];
    assign xy_1_o = w_xy[1];

endmodule

// File: tb/tb_roi_ctrl.sv
// Directed testbench for roi_ctrl: APB register access, frame-synchronous commit, range check,
// enable FSM and frame counter wrap (counter expectations follow ROI_CTRL_FRAME_CNT_EN).
module tb_roi_ctrl;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        tvalid, tlast;
    logic [31:0] pwdata;
    logic [11:0] paddr;
    logic        pwrite, psel, penable;
    logic        pready;
    logic [31:0] prdata;
    logic [31:0] xy0, xy1;
    logic        roi_en, irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd;
    logic [31:0] cnt_exp;

    roi_ctrl dut (
        .clk_i         (clk),
        .arst_i        (arst_n),
        .tvalid_i      (tvalid),
        .tlast_i       (tlast),
        .apb_pwdata_i  (pwdata),
        .apb_paddr_i   (paddr),
        .apb_pwrite_i  (pwrite),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_pready_o  (pready),
        .apb_prdata_o  (prdata),
        .xy_0_o        (xy0),
        .xy_1_o        (xy1),
        .roi_en_o      (roi_en),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic with_eof);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        tvalid = with_eof; tlast = with_eof;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        tvalid = 1'b0; tlast = 1'b0;
        $display("apb write addr=0x%03h data=0x%08h eof=%0b", a, d, with_eof);
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        d = prdata;
        check("pready", {31'd0, pready}, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        $display("apb read  addr=0x%03h data=0x%08h", a, d);
    endtask

    task automatic eof_pulse();
        tvalid = 1'b1; tlast = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
        $display("eof pulse");
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        arst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        pwdata = '0; paddr = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        idle();

        // Reset state
        check("rst_xy0", xy0, 32'h0000_0000);
        check("rst_xy1", xy1, 32'h031F_0257);
        check("rst_roi_en", {31'd0, roi_en}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        apb_read(12'h00C, rd); check("rst_status", rd, 32'd0);
        apb_read(12'h008, rd); check("rst_sh_xy1", rd, 32'h031F_0257);
        apb_read(12'h010, rd); check("rst_fcnt", rd, 32'd0);
        apb_read(12'h020, rd); check("unmapped_rd", rd, 32'd0);

        // Valid commit applies only at EOF
        apb_write(12'h004, 32'h0064_0032, 1'b0);
        apb_write(12'h008, 32'h00C8_0096, 1'b0);
        apb_read(12'h004, rd); check("sh_xy0_rb", rd, 32'h0064_0032);
        apb_write(12'h000, 32'h0000_0002, 1'b0);
        apb_read(12'h00C, rd); check("pend_set", rd, 32'h1);
        apb_read(12'h000, rd); check("ctrl_pend", rd, 32'h2);
        idle(); idle();
        check("pre_eof_xy0", xy0, 32'h0000_0000);
        check("pre_eof_xy1", xy1, 32'h031F_0257);
        eof_pulse();
        check("cmt_xy0", xy0, 32'h0064_0032);
        check("cmt_xy1", xy1, 32'h00C8_0096);
        apb_read(12'h00C, rd); check("pend_clr", rd, 32'h0);

        // Out-of-range corner (x1 = 800) raises cfg_err
        apb_write(12'h008, 32'h0320_0000, 1'b0);
        apb_write(12'h000, 32'h0000_0002, 1'b0);
        eof_pulse();
        check("err_irq", {31'd0, irq}, 32'd1);
        check("err_xy1_keep", xy1, 32'h00C8_0096);
        apb_read(12'h00C, rd); check("err_status", rd, 32'h2);
        apb_write(12'h00C, 32'h0000_0002, 1'b0);
        check("w1c_irq", {31'd0, irq}, 32'd0);

        // Commit coinciding with EOF waits for the next EOF
        apb_write(12'h008, 32'h012C_00C8, 1'b0);
        apb_write(12'h000, 32'h0000_0002, 1'b1);
        check("same_eof_xy1", xy1, 32'h00C8_0096);
        apb_read(12'h00C, rd); check("same_eof_pend", rd, 32'h1);
        eof_pulse();
        check("next_eof_xy1", xy1, 32'h012C_00C8);

        // W1C racing a fresh failure keeps cfg_err
        apb_write(12'h004, 32'h03FF_0000, 1'b0);
        apb_write(12'h000, 32'h0000_0002, 1'b0);
        apb_write(12'h00C, 32'h0000_0002, 1'b1);
        check("race_irq", {31'd0, irq}, 32'd1);
        check("race_xy0_keep", xy0, 32'h0064_0032);
        apb_write(12'h00C, 32'h0000_0002, 1'b0);
        check("race_w1c", {31'd0, irq}, 32'd0);
        apb_write(12'h123, 32'hFFFF_FFFF, 1'b0);
        apb_read(12'h000, rd); check("unmapped_wr", rd, 32'h0);

        // Enable FSM: OFF -> ARM -> RUN -> DRAIN -> OFF
        apb_write(12'h000, 32'h0000_0001, 1'b0);
        idle();
        check("arm_roi_en", {31'd0, roi_en}, 32'd0);
        apb_read(12'h00C, rd); check("arm_status", rd, 32'h0);
        eof_pulse();
        check("run_roi_en", {31'd0, roi_en}, 32'd1);
        apb_read(12'h00C, rd); check("run_status", rd, 32'h4);
        eof_pulse();
        apb_write(12'h000, 32'h0000_0000, 1'b0);
        idle();
        check("drain_roi_en", {31'd0, roi_en}, 32'd1);
        eof_pulse();
        check("off_roi_en", {31'd0, roi_en}, 32'd0);
`ifdef ROI_CTRL_FRAME_CNT_EN
        cnt_exp = 32'd1;
`else
        cnt_exp = 32'd0;
`endif
        apb_read(12'h010, rd); check("fcnt_one", rd, cnt_exp);

        // DRAIN -> RUN re-entry, then run the counter to its wrap
        apb_write(12'h000, 32'h0000_0001, 1'b0);
        idle();
        eof_pulse();
        apb_write(12'h000, 32'h0000_0000, 1'b0);
        apb_write(12'h000, 32'h0000_0001, 1'b0);
        idle();
        eof_pulse();
        check("rerun_roi_en", {31'd0, roi_en}, 32'd1);
        tvalid = 1'b1; tlast = 1'b1;
        repeat (65533) @(posedge clk);
        #1 tvalid = 1'b0; tlast = 1'b0;
        $display("eof burst of 65533");
`ifdef ROI_CTRL_FRAME_CNT_EN
        cnt_exp = 32'h0000_FFFF;
`else
        cnt_exp = 32'd0;
`endif
        apb_read(12'h010, rd); check("fcnt_max", rd, cnt_exp);
        eof_pulse();
        apb_read(12'h010, rd); check("fcnt_wrap", rd, 32'd0);

        // Reset during an APB access abandons it
        psel = 1'b1; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h0001_0001; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; arst_n = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; arst_n = 1'b1;
        $display("reset during apb access");
        check("mrst_roi_en", {31'd0, roi_en}, 32'd0);
        check("mrst_xy1", xy1, 32'h031F_0257);
        apb_read(12'h004, rd); check("mrst_sh_xy0", rd, 32'h0);
        eof_pulse();
        check("mrst_eof_xy0", xy0, 32'h0);
        apb_read(12'h010, rd); check("mrst_fcnt", rd, 32'd0);
        apb_read(12'h00C, rd); check("mrst_status", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/roi_ctrl.md
ROI_CTRL -- requirements
Module: roi_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 800, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 600, frame height in lines.
REQ-003 SHALL have parameter APB_DATA_W, default 32, APB data width.
REQ-004 SHALL have parameter APB_ADDR_W, default 12, APB address width.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port arst_i, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have ports tvalid_i and tlast_i, input, 1 each, monitored copy of the input-stream handshake (frame end = tvalid_i & tlast_i, "EOF").
REQ-008 SHALL have APB slave ports apb_pwdata_i (APB_DATA_W), apb_paddr_i (APB_ADDR_W), apb_pwrite_i, apb_psel_i and apb_penable_i (inputs), plus apb_pready_o (1) and apb_prdata_o (APB_DATA_W) (outputs).
REQ-009 SHALL have outputs xy_0_o and xy_1_o, APB_DATA_W each, active ROI corners, x in [26:16], y in [9:0].
REQ-010 SHALL have output roi_en_o, 1, ROI datapath enable.
REQ-011 SHALL have output irq_o, 1, level interrupt = sticky cfg_err.

Function
REQ-012 SHALL assert apb_pready_o = apb_psel_i & apb_penable_i, with zero wait states.
REQ-013 SHALL perform writes in the access phase, and SHALL drive apb_prdata_o in the access phase with the selected register; unmapped reads return 0 and unmapped writes are ignored.
REQ-014 SHALL implement this map: 0x000 CTRL (bit0 enable RW; bit1 commit W1S, reads pending); 0x004 XY0 shadow RW; 0x008 XY1 shadow RW; 0x00C STATUS (bit0 pending RO; bit1 cfg_err W1C; bit2 running RO); 0x010 FRAME_CNT RO.
REQ-015 SHALL, on a commit write, set pending; an EOF in the same cycle SHALL NOT consume it, so it applies at the following EOF.
REQ-016 SHALL, at EOF with pending set, check the shadows: x0<=x1<WIDTH and y0<=y1<HEIGHT.
REQ-017 SHALL, when the shadow check passes, copy the shadows to xy_0_o/xy_1_o on the next cycle; when it fails, set cfg_err and keep the active values. Either way pending clears.
REQ-018 SHALL use the shadow value present in the EOF cycle when a shadow write occurs while pending.
REQ-019 SHALL implement an FSM with states OFF, ARM, RUN and DRAIN; roi_en_o=1 only in RUN and DRAIN.
REQ-020 SHALL take these transitions:
- OFF->ARM on enable=1.
- ARM->RUN at EOF.
- ARM->OFF on enable=0.
- RUN->DRAIN on enable=0.
- DRAIN->OFF at EOF.
- DRAIN->RUN on enable=1 before EOF.
REQ-021 SHALL allow commits in every state.
REQ-022 SHALL, when a cfg_err W1C coincides with a new failure, keep cfg_err=1.
REQ-023 SHALL increment FRAME_CNT (16 bit) at each EOF while in RUN, wrapping 0xFFFF->0.
REQ-024 SHALL have STATUS.running = RUN or DRAIN.

Reset
REQ-025 SHALL, with arst_i low at a clock edge, reset to:
- State OFF; enable=0, pending=0, cfg_err=0, FRAME_CNT=0.
- roi_en_o=0, irq_o=0.
- xy_0_o=0 and xy_1_o={x=WIDTH-1, y=HEIGHT-1}; shadows likewise.
REQ-026 SHALL, when reset is asserted mid-frame or mid-APB access, abandon the access and return to the reset state; the first EOF after reset SHALL NOT commit or count.

Configuration
REQ-027 SHALL, with ROI_CTRL_FRAME_CNT_EN defined, implement FRAME_CNT per REQ-023.
REQ-028 SHALL, without ROI_CTRL_FRAME_CNT_EN, instantiate no counter flops and read 0x010 as 0.

Structure
REQ-029 SHALL place the register offsets, the CTRL/STATUS bit indices, the coordinate field LSB/MSB constants and the FSM state enum in package roi_pkg.
REQ-030 SHALL place the APB decode and register file in sub-module roi_ctrl_regs; the FSM, commit and check logic remain in roi_ctrl.

Verification
REQ-031 SHALL verify: reset -> xy_0_o=0, xy_1_o=0x031F0257, roi_en_o=0.
REQ-032 SHALL verify: write XY0=0x00640032, XY1=0x00C80096, then commit -> outputs unchanged until the first EOF, updated 1 cycle later, pending=0.
REQ-033 SHALL verify: XY1=0x03200000 (x1=800) and commit, then EOF -> cfg_err=1, irq_o=1, active unchanged; W1C clears irq_o.
REQ-034 SHALL verify: commit write in the same cycle as EOF -> no update; update at the next EOF.
REQ-035 SHALL verify: enable=1 mid-frame -> roi_en_o rises only after EOF; enable=0 mid-frame -> roi_en_o falls after the next EOF; FRAME_CNT=1.
REQ-036 SHALL verify: preload FRAME_CNT near the wrap with 65536 EOFs in RUN -> it reads 0; with the macro undefined it reads 0 always.
